// File: rtl/vga_pattern_gen.sv
// ============================================================================
//  Module      : vga_pattern_gen
//  Description : VGA raster timing generator with a runtime-selectable test
//                pattern (colour bars, checkerboard, solid colour, moving
//                block). Produces one RGB565 stream with hs/vs/de. Every
//                output is registered one clock behind the raster counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pattern_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pat_sel,
    input  logic [15:0] solid_rgb,
    output logic        hs_out,
    output logic        vs_out,
    output logic        de_out,
    output logic [15:0] vga_out,
    output logic        frame_start
);

    // ------------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int RW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] c_H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] c_V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] c_H_ACT     = HW'(H_ACTIVE);
    localparam logic [VW-1:0] c_V_ACT     = VW'(V_ACTIVE);
    localparam logic [HW-1:0] c_HS_FIRST  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] c_HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] c_VS_FIRST  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] c_VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [RW-1:0] c_BAR_LAST  = RW'(BAR_W - 1);

    // Moving block: 64x64, vertically centred, left edge steps 4 px per frame
    localparam logic [VW-1:0] c_BY_FIRST  = VW'(V_ACTIVE / 2 - 32);
    localparam logic [VW-1:0] c_BY_LAST   = VW'(V_ACTIVE / 2 + 31);
    localparam logic [HW:0]   c_BX_LIMIT  = (HW+1)'(H_ACTIVE - 64);
    localparam logic [HW:0]   c_BX_STEP   = (HW+1)'(4);
    localparam logic [HW:0]   c_BLK_W     = (HW+1)'(64);

    // Pattern codes
    localparam logic [1:0] c_PAT_BARS  = 2'd0;
    localparam logic [1:0] c_PAT_CHECK = 2'd1;
    localparam logic [1:0] c_PAT_SOLID = 2'd2;
    localparam logic [1:0] c_PAT_BLOCK = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic [RW-1:0] r_bar_run;     // position inside the current colour bar
    logic [2:0]    r_bar_idx;     // which of the 8 bars h_cnt is in
    logic [1:0]    r_pat_q;       // pattern latched at the start of the frame
    logic [7:0]    r_frame_cnt;
    logic [HW-1:0] r_bx;          // left edge of the moving block

    logic          w_frame_first;
    logic          w_frame_last;
    logic          w_line_last;
    logic [1:0]    w_pat;
    logic          w_de;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_in_block;
    logic [HW:0]   w_bx_inc;
    logic [HW-1:0] w_bx_next;
    logic [15:0]   w_bar_rgb;
    logic [15:0]   w_rgb;

    assign w_line_last   = (r_h_cnt == c_H_LAST);
    assign w_frame_first = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_frame_last  = w_line_last && (r_v_cnt == c_V_LAST);

    // Pixel (0,0) already belongs to the new frame, so it uses the selector
    // value being latched in this very cycle rather than the stale copy.
    assign w_pat = w_frame_first ? pat_sel : r_pat_q;

    assign w_de     = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    assign w_hs_act = (r_h_cnt >= c_HS_FIRST) && (r_h_cnt <= c_HS_LAST);
    assign w_vs_act = (r_v_cnt >= c_VS_FIRST) && (r_v_cnt <= c_VS_LAST);

    assign w_in_block = ({1'b0, r_h_cnt} >= {1'b0, r_bx}) &&
                        ({1'b0, r_h_cnt} <  ({1'b0, r_bx} + c_BLK_W)) &&
                        (r_v_cnt >= c_BY_FIRST) && (r_v_cnt <= c_BY_LAST);

    // Wrap the block back to the left once the next step would push it
    // past the right edge of the active area.
    assign w_bx_inc  = {1'b0, r_bx} + c_BX_STEP;
    assign w_bx_next = (w_bx_inc > c_BX_LIMIT) ? '0 : w_bx_inc[HW-1:0];

    // Raster counters plus the run-length bar tracker that follows h_cnt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_bar_run <= '0;
            r_bar_idx <= '0;
        end else if (w_line_last) begin
            r_h_cnt   <= '0;
            r_bar_run <= '0;
            r_bar_idx <= '0;
            r_v_cnt   <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
            if (r_bar_run == c_BAR_LAST) begin
                r_bar_run <= '0;
                r_bar_idx <= r_bar_idx + 1'b1;
            end else begin
                r_bar_run <= r_bar_run + 1'b1;
            end
        end
    end

    // Per-frame state: pattern latch, frame counter and block position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat_q     <= '0;
            r_frame_cnt <= '0;
            r_bx        <= '0;
        end else begin
            if (w_frame_first) begin
                r_pat_q <= pat_sel;
            end
            if (w_frame_last) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
                r_bx        <= w_bx_next;
            end
        end
    end

    // Colour-bar palette indexed by the run-length bar counter
    always_comb begin
        w_bar_rgb = 16'h0000;
        case (r_bar_idx)
            3'd0:    w_bar_rgb = 16'hFFFF;
            3'd1:    w_bar_rgb = 16'hFFE0;
            3'd2:    w_bar_rgb = 16'h07FF;
            3'd3:    w_bar_rgb = 16'h07E0;
            3'd4:    w_bar_rgb = 16'hF81F;
            3'd5:    w_bar_rgb = 16'hF800;
            3'd6:    w_bar_rgb = 16'h001F;
            default: w_bar_rgb = 16'h0000;
        endcase
    end

    // Pattern select; blanking forces black outside the active area
    always_comb begin
        w_rgb = 16'h0000;
        case (w_pat)
            c_PAT_BARS:  w_rgb = w_bar_rgb;
            c_PAT_CHECK: w_rgb = (r_h_cnt[5] ^ r_v_cnt[5]) ? 16'hFFFF : 16'h0000;
            c_PAT_SOLID: w_rgb = solid_rgb;
            c_PAT_BLOCK: w_rgb = w_in_block ? 16'hF800 : 16'h001F;
            default:     w_rgb = 16'h0000;
        endcase
        if (!w_de) begin
            w_rgb = 16'h0000;
        end
    end

    // Output register stage: all video outputs share one clock of latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_out      <= ~SYNC_POL;
            vs_out      <= ~SYNC_POL;
            de_out      <= 1'b0;
            vga_out     <= 16'h0000;
            frame_start <= 1'b0;
        end else begin
            hs_out      <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            vs_out      <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            de_out      <= w_de;
            vga_out     <= w_rgb;
            frame_start <= w_frame_first;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
// ============================================================================
//  Module      : tb_vga_pattern_gen
//  Description : Self-checking bench for vga_pattern_gen on a reduced raster
//                (80x68 active, 88x74 total) so many frames fit in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_pattern_gen;

    localparam int HA = 80, HF = 2, HS = 4, HB = 2;
    localparam int VA = 68, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 88
    localparam int VT = VA + VF + VS + VB;   // 74
    localparam int BOUND = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pat_sel = 2'd0;
    logic [15:0] solid_rgb = 16'h07E0;
    logic        hs_out, vs_out, de_out, frame_start;
    logic [15:0] vga_out;

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .pat_sel(pat_sel), .solid_rgb(solid_rgb),
        .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
        .vga_out(vga_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x, y, ep, frm;
        logic        hs, vs, de, fs;
        logic [15:0] rgb;
    } exp_t;

    typedef struct {
        int          ep, frm, x, y;
        logic        de;
        logic [15:0] rgb;
    } vec_t;

    localparam int NVEC = 36;
    vec_t tbl [NVEC];
    int   hits [NVEC];

    exp_t q [$];
    int   errors = 0;
    int   checks = 0;

    // reference model state (counters of the pixel the DUT is computing now)
    int mx = 0, my = 0, mfrm = 0, mbx = 0, mpat = 0;
    int ep = 0;

    logic [15:0] bar_col [8];

    function automatic logic [15:0] model_rgb(int pat, int x, int y, int bx,
                                              logic [15:0] solid);
        if (x >= HA || y >= VA) return 16'h0000;
        case (pat)
            0: return bar_col[x / (HA / 8)];
            1: return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 16'hFFFF : 16'h0000;
            2: return solid;
            default: return (x >= bx && x < bx + 64 && y >= VA / 2 - 32 && y < VA / 2 + 32)
                            ? 16'hF800 : 16'h001F;
        endcase
    endfunction

    // scoreboard producer: expected output for each clock edge
    initial begin
        exp_t e;
        int   p;
        bar_col = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                    16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                mx = 0; my = 0; mfrm = 0; mbx = 0; mpat = 0;
            end else begin
                if (mx == 0 && my == 0) mpat = int'(pat_sel);
                p = mpat;
                e.x = mx; e.y = my; e.ep = ep; e.frm = mfrm;
                e.hs  = (mx >= HA + HF && mx < HA + HF + HS) ? 1'b0 : 1'b1;
                e.vs  = (my >= VA + VF && my < VA + VF + VS) ? 1'b0 : 1'b1;
                e.de  = (mx < HA && my < VA);
                e.fs  = (mx == 0 && my == 0);
                e.rgb = model_rgb(p, mx, my, mbx, solid_rgb);
                q.push_back(e);
                mx++;
                if (mx == HT) begin
                    mx = 0;
                    my++;
                    if (my == VT) begin
                        my = 0;
                        mfrm++;
                        mbx = (mbx + 4 > HA - 64) ? 0 : mbx + 4;
                    end
                end
            end
        end
    end

    // scoreboard consumer, table spot checks and sync timing measurement
    int   cyc = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1;
    int   hfall = 0, vfall = 0;
    bit   have_hf = 0, have_vf = 0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            checks++;
            if (hs_out !== 1'b1 || vs_out !== 1'b1 || de_out !== 1'b0 ||
                vga_out !== 16'h0000 || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_vals: got hs=%b vs=%b de=%b rgb=%h fs=%b, want 1 1 0 0000 0",
                         hs_out, vs_out, de_out, vga_out, frame_start);
            end
            have_hf = 0; have_vf = 0; prev_hs = 1'b1; prev_vs = 1'b1;
        end else if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty at cycle %0d", cyc);
        end else begin
            e = q.pop_front();
            checks++;
            if (hs_out !== e.hs || vs_out !== e.vs || de_out !== e.de ||
                vga_out !== e.rgb || frame_start !== e.fs) begin
                errors++;
                $display("FAIL pix(%0d,%0d) ep%0d f%0d: got hs=%b vs=%b de=%b rgb=%h fs=%b, want hs=%b vs=%b de=%b rgb=%h fs=%b",
                         e.x, e.y, e.ep, e.frm, hs_out, vs_out, de_out, vga_out, frame_start,
                         e.hs, e.vs, e.de, e.rgb, e.fs);
            end
            for (int i = 0; i < NVEC; i++) begin
                if (tbl[i].ep == e.ep && tbl[i].frm == e.frm &&
                    tbl[i].x == e.x && tbl[i].y == e.y) begin
                    hits[i]++;
                    checks++;
                    if (de_out !== tbl[i].de || vga_out !== tbl[i].rgb) begin
                        errors++;
                        $display("FAIL vec%0d (%0d,%0d): got de=%b rgb=%h, want de=%b rgb=%h",
                                 i, e.x, e.y, de_out, vga_out, tbl[i].de, tbl[i].rgb);
                    end
                end
            end
            if (prev_hs && !hs_out) begin
                if (have_hf) begin
                    checks++;
                    if (cyc - hfall != HT) begin
                        errors++;
                        $display("FAIL hs_period: got %0d, want %0d", cyc - hfall, HT);
                    end
                end
                hfall = cyc; have_hf = 1;
            end
            if (!prev_hs && hs_out && have_hf) begin
                checks++;
                if (cyc - hfall != HS) begin
                    errors++;
                    $display("FAIL hs_low: got %0d, want %0d", cyc - hfall, HS);
                end
            end
            if (prev_vs && !vs_out) begin
                if (have_vf) begin
                    checks++;
                    if (cyc - vfall != HT * VT) begin
                        errors++;
                        $display("FAIL vs_period: got %0d, want %0d", cyc - vfall, HT * VT);
                    end
                end
                vfall = cyc; have_vf = 1;
            end
            if (!prev_vs && vs_out && have_vf) begin
                checks++;
                if (cyc - vfall != HT * VS) begin
                    errors++;
                    $display("FAIL vs_low: got %0d, want %0d", cyc - vfall, HT * VS);
                end
            end
            prev_hs = hs_out;
            prev_vs = vs_out;
        end
    end

    task automatic timeout(input string what);
        checks++; errors++;
        $display("FAIL timeout waiting for %s", what);
    endtask

    initial begin
        int n;
        // ep, frame, x, y, de, rgb -- hand-derived for the 80x68 raster
        tbl = '{
            '{0, 0,  0,  0, 1'b1, 16'hFFFF}, '{0, 0,  9,  0, 1'b1, 16'hFFFF},
            '{0, 0, 10,  0, 1'b1, 16'hFFE0}, '{0, 0, 35,  5, 1'b1, 16'h07E0},
            '{0, 0, 45,  3, 1'b1, 16'hF81F}, '{0, 0, 55,  3, 1'b1, 16'hF800},
            '{0, 0, 65, 50, 1'b1, 16'h001F}, '{0, 0, 79,  0, 1'b1, 16'h0000},
            '{0, 0, 80,  0, 1'b0, 16'h0000}, '{0, 0, 15, 60, 1'b1, 16'hFFE0},
            '{0, 0, 25, 40, 1'b1, 16'h07FF},
            '{0, 1,  0,  0, 1'b1, 16'h07E0}, '{0, 1, 79, 67, 1'b1, 16'h07E0},
            '{0, 1, 80, 67, 1'b0, 16'h0000}, '{0, 1,  0, 70, 1'b0, 16'h0000},
            '{0, 2, 31,  0, 1'b1, 16'h0000}, '{0, 2, 32,  0, 1'b1, 16'hFFFF},
            '{0, 2, 32, 32, 1'b1, 16'h0000}, '{0, 2,  0, 32, 1'b1, 16'hFFFF},
            '{0, 3, 12,  2, 1'b1, 16'hF800}, '{0, 3, 11,  2, 1'b1, 16'h001F},
            '{0, 3, 75, 19, 1'b1, 16'hF800}, '{0, 3, 76, 19, 1'b1, 16'h001F},
            '{0, 3, 12,  1, 1'b1, 16'h001F},
            '{1, 0,  0,  2, 1'b1, 16'hF800}, '{1, 0, 63,  2, 1'b1, 16'hF800},
            '{1, 0, 64,  2, 1'b1, 16'h001F}, '{1, 1,  4, 30, 1'b1, 16'hF800},
            '{1, 1,  3, 30, 1'b1, 16'h001F}, '{1, 2,  8, 30, 1'b1, 16'hF800},
            '{1, 4, 16, 30, 1'b1, 16'hF800}, '{1, 4, 79, 30, 1'b1, 16'hF800},
            '{1, 4, 15, 30, 1'b1, 16'h001F}, '{1, 5,  0, 30, 1'b1, 16'hF800},
            '{1, 5, 64, 30, 1'b1, 16'h001F}, '{1, 3, 12, 30, 1'b1, 16'hF800}
        };
        for (int i = 0; i < NVEC; i++) hits[i] = 0;

        // reset, then frame 0 in colour bars
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // mid-frame switch to solid: frame 0 stays bars, frame 1 solid
        n = 0;
        do begin @(negedge clk); n++; end while (!(mfrm == 0 && my == 30) && n < BOUND);
        if (n >= BOUND) timeout("line 30");
        #1 pat_sel = 2'd2;

        n = 0;
        do begin @(negedge clk); n++; end while (!(mfrm == 1 && my == 10) && n < BOUND);
        if (n >= BOUND) timeout("frame1");
        #1 pat_sel = 2'd1;

        n = 0;
        do begin @(negedge clk); n++; end while (!(mfrm == 2 && my == 10) && n < BOUND);
        if (n >= BOUND) timeout("frame2");
        #1 pat_sel = 2'd3;

        // asynchronous reset in the middle of frame 3
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(mfrm == 3 && my == 20 && mx == 30) && n < BOUND);
        if (n >= BOUND) timeout("reset point");
        #1 rst = 1'b1;
        #1;
        checks++;
        if (hs_out !== 1'b1 || vs_out !== 1'b1 || de_out !== 1'b0 ||
            vga_out !== 16'h0000 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got hs=%b vs=%b de=%b rgb=%h fs=%b, want 1 1 0 0000 0",
                     hs_out, vs_out, de_out, vga_out, frame_start);
        end
        ep = 1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // moving block across the wrap of its left edge
        n = 0;
        do begin @(negedge clk); n++; end while (!(mfrm == 5 && my == 40) && n < 6 * BOUND);
        if (n >= 6 * BOUND) timeout("block frames");

        for (int i = 0; i < NVEC; i++) begin
            checks++;
            if (hits[i] != 1) begin
                errors++;
                $display("FAIL vec%0d_reached: got %0d hits, want 1", i, hits[i]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
